// File: rtl/magic_config_loader.sv
// magic_config_loader
//
// Boot-time loader for the magic configuration registers. It reads a saved
// image from a 25xx-series SPI EEPROM (read command 0x03, 16-bit address),
// checks the 0xEB header byte and the XOR checksum byte, and replays the
// image as a burst of config write strobes. The top level ORs those strobes
// into the same config-write path the magic ROM drives with OUT (xxFF).
//
// Image layout at BASE_ADDR: header (0xEB), NREGS data bytes, checksum byte.
//
// Optional feature macro: MAGIC_LOADER_CHECKSUM_EN
//   defined   - the checksum byte is read and must equal the XOR of the data
//   undefined - no checksum byte is read; only the header gates the replay
//
// Parameters:
//   CLK_DIV   - SCK half-period in clk28 cycles
//   BASE_ADDR - EEPROM byte address of the image header
//   NREGS     - number of config registers (config addresses 1..NREGS)
//
// Ports:
//   clk28    in   system clock
//   rst      in   synchronous active-high reset
//   reload   in   single-cycle pulse, starts a new load (only honoured in DONE)
//   spi_cs_n out  EEPROM chip select, active low
//   spi_sck  out  SPI clock, mode 0, idles low
//   spi_mosi out  serial data to the EEPROM
//   spi_miso in   serial data from the EEPROM
//   cfg_wr   out  one-cycle config write strobe
//   cfg_addr out  config register index (bus A[15:8] equivalent)
//   cfg_data out  config write data
//   busy     out  a load is in progress
//   valid    out  last load passed all checks and was replayed
module magic_config_loader #(
  parameter int          CLK_DIV   = 4,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          NREGS     = 16
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       reload,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       cfg_wr,
  output logic [7:0] cfg_addr,
  output logic [7:0] cfg_data,
  output logic       busy,
  output logic       valid
);

  localparam int              DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int              IW        = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [DW-1:0]   DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [4:0]      LAST_REG  = 5'(NREGS - 1);
  localparam logic [4:0]      REG_END   = 5'(NREGS);
  localparam logic [23:0]     CMD_WORD  = {8'h03, BASE_ADDR};
  localparam logic [7:0]      HDR_MAGIC = 8'hEB;

  typedef enum logic [2:0] {
    IDLE, CMD, HDR, DATA, SUM, REPLAY, DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [DW-1:0]   div_cnt;
  logic [2:0]      bit_cnt;
  logic [4:0]      byte_cnt;
  logic            tail;
  logic [23:0]     tx_shift;
  logic [7:0]      rx_shift;
  logic [7:0]      data_buf [NREGS];
`ifdef MAGIC_LOADER_CHECKSUM_EN
  logic [7:0]      xor_acc;
  logic            sum_ok;
`endif

  logic spi_active;
  logic tick;
  logic sck_rise;
  logic sck_fall;
  logic byte_done;
  logic tail_done;

  // The half-period divider only runs while the chip is selected. 'tail' is
  // the final half-period with SCK low before chip select is released, so no
  // new SCK rise may start during it.
  assign spi_active = state inside {CMD, HDR, DATA, SUM};
  assign tick       = spi_active && (div_cnt == DIV_LAST);
  assign sck_rise   = tick && !spi_sck && !tail;
  assign sck_fall   = tick && spi_sck;
  assign tail_done  = tick && tail;
  // rx_shift already holds all eight bits at the falling edge of the 8th bit.
  assign byte_done  = sck_fall && (bit_cnt == 3'd7);
  assign busy       = (state != DONE);

  // State register.
  always_ff @(posedge clk28) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic. Every transition is tied to a byte boundary, the end of
  // the chip-select tail, or the end of the replay burst.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   state_next = CMD;
      CMD:    if (byte_done && byte_cnt == 5'd2) state_next = HDR;
      HDR: begin
        if (tail_done)                                 state_next = DONE;
        else if (byte_done && rx_shift == HDR_MAGIC)   state_next = DATA;
      end
`ifdef MAGIC_LOADER_CHECKSUM_EN
      DATA:   if (byte_done && byte_cnt == LAST_REG) state_next = SUM;
      SUM:    if (tail_done) state_next = sum_ok ? REPLAY : DONE;
`else
      DATA:   if (tail_done) state_next = REPLAY;
`endif
      REPLAY: if (byte_cnt == REG_END) state_next = DONE;
      DONE:   if (reload) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Image buffer; contents are meaningless until DATA refills them.
  always_ff @(posedge clk28) begin
    if (state == DATA && byte_done) data_buf[byte_cnt[IW-1:0]] <= rx_shift;
  end

  // SPI shifter, byte/bit counters and the replay strobes. tx_shift holds the
  // bits still to be sent after the one currently on spi_mosi.
  always_ff @(posedge clk28) begin
    if (rst) begin
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      cfg_wr   <= 1'b0;
      cfg_addr <= 8'h00;
      cfg_data <= 8'h00;
      valid    <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= 3'd0;
      byte_cnt <= 5'd0;
      tail     <= 1'b0;
      tx_shift <= 24'h0;
      rx_shift <= 8'h00;
`ifdef MAGIC_LOADER_CHECKSUM_EN
      xor_acc  <= 8'h00;
      sum_ok   <= 1'b0;
`endif
    end else begin
      cfg_wr <= 1'b0;

      if (!spi_active || tick) div_cnt <= '0;
      else                     div_cnt <= div_cnt + 1'b1;

      if (sck_rise) begin
        spi_sck  <= 1'b1;
        rx_shift <= {rx_shift[6:0], spi_miso};
      end

      if (sck_fall) begin
        spi_sck  <= 1'b0;
        bit_cnt  <= bit_cnt + 3'd1;
        spi_mosi <= tx_shift[23];
        tx_shift <= {tx_shift[22:0], 1'b0};
      end

      if (tail_done) begin
        tail     <= 1'b0;
        spi_cs_n <= 1'b1;
      end

      case (state)
        IDLE: begin
          // First command bit is presented together with chip select.
          spi_cs_n <= 1'b0;
          spi_mosi <= CMD_WORD[23];
          tx_shift <= {CMD_WORD[22:0], 1'b0};
          bit_cnt  <= 3'd0;
          byte_cnt <= 5'd0;
          tail     <= 1'b0;
`ifdef MAGIC_LOADER_CHECKSUM_EN
          xor_acc  <= 8'h00;
`endif
        end
        CMD: begin
          if (byte_done) byte_cnt <= (byte_cnt == 5'd2) ? 5'd0 : byte_cnt + 5'd1;
        end
        HDR: begin
          if (byte_done && rx_shift != HDR_MAGIC) tail <= 1'b1;
        end
        DATA: begin
          if (byte_done) begin
`ifdef MAGIC_LOADER_CHECKSUM_EN
            xor_acc <= xor_acc ^ rx_shift;
`endif
            if (byte_cnt == LAST_REG) begin
              byte_cnt <= 5'd0;
`ifndef MAGIC_LOADER_CHECKSUM_EN
              tail     <= 1'b1;
`endif
            end else begin
              byte_cnt <= byte_cnt + 5'd1;
            end
          end
        end
`ifdef MAGIC_LOADER_CHECKSUM_EN
        SUM: begin
          if (byte_done) begin
            sum_ok <= (rx_shift == xor_acc);
            tail   <= 1'b1;
          end
        end
`endif
        REPLAY: begin
          // One strobe per cycle; valid rises as the burst ends.
          if (byte_cnt != REG_END) begin
            cfg_wr   <= 1'b1;
            cfg_addr <= {3'b000, byte_cnt} + 8'd1;
            cfg_data <= data_buf[byte_cnt[IW-1:0]];
            byte_cnt <= byte_cnt + 5'd1;
          end else begin
            valid    <= 1'b1;
          end
        end
        DONE: begin
          if (reload) valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
